// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the scoreboard-based hazard unit.
//   - TUSE_NONE    : Tuse code meaning "operand not read" (default 3-bit width)
//   - TNEW_*       : Tnew values for the common producer classes
//   - hz_entry_t   : one in-flight destination write {valid, dst, tnew}
//   - tnew_age     : saturating one-cycle decrement of a Tnew value
package hazard_pkg;

  // Entry fields are sized for the largest supported configuration.
  // Narrower register/Tnew codes are zero-extended into them, and the
  // constant upper bits disappear in synthesis.
  localparam int ENT_REG_W = 8;
  localparam int ENT_TW    = 8;

  localparam logic [2:0] TUSE_NONE = 3'b111;

  localparam logic [2:0] TNEW_ALU  = 3'd1;
  localparam logic [2:0] TNEW_LOAD = 3'd2;
  localparam logic [2:0] TNEW_PC8  = 3'd0;

  typedef struct packed {
    logic                 valid;
    logic [ENT_REG_W-1:0] dst;
    logic [ENT_TW-1:0]    tnew;
  } hz_entry_t;

  // A result that already exists stays available (0 stays 0).
  function automatic logic [ENT_TW-1:0] tnew_age(input logic [ENT_TW-1:0] t);
    return (t == '0) ? t : (t - ENT_TW'(1));
  endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match
//   Youngest-match search of one D-stage source operand against the
//   in-flight write entries.
//   Ports:
//     valid_i  : D holds a real instruction
//     src_i    : source register number
//     tuse_i   : cycles until the operand is needed, all-ones = not read
//     ent_i    : entries, index 0 = E (stage 1) .. STAGES-1 = oldest
//     stall_o  : youngest producer will not have its result in time
//     fwd_o    : stage number to forward from, 0 = register file
module hazard_match
  import hazard_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int REG_W  = 5,
  parameter int TW     = 3,
  parameter int FW     = 2
) (
  input  logic             valid_i,
  input  logic [REG_W-1:0] src_i,
  input  logic [TW-1:0]    tuse_i,
  input  hz_entry_t        ent_i [STAGES],
  output logic             stall_o,
  output logic [FW-1:0]    fwd_o
);

  localparam logic [TW-1:0] TUSE_NONE_L = {TW{1'b1}};

  logic [STAGES-1:0] stage_hit;
  logic              lookup;
  logic              hit;
  logic [FW-1:0]     hit_idx;
  logic [ENT_TW-1:0] hit_tnew;

  // r0 is never a real dependency and unread operands never match.
  assign lookup = valid_i && (src_i != '0) && (tuse_i != TUSE_NONE_L);

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage_hit
    assign stage_hit[gi] = ent_i[gi].valid && (ent_i[gi].dst == ENT_REG_W'(src_i));
  end

  // Scan oldest to youngest so the youngest match overwrites: an older
  // write to the same register is shadowed by a newer one.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_tnew = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (stage_hit[k]) begin
        hit      = 1'b1;
        hit_idx  = FW'(k + 1);
        hit_tnew = ent_i[k].tnew;
      end
    end
  end

  assign stall_o = lookup && hit && (hit_tnew > ENT_TW'(tuse_i));
  assign fwd_o   = (lookup && hit && (hit_tnew == '0)) ? hit_idx : '0;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   D-stage hazard unit built on a shift register of in-flight GRF writes
//   plus a HI/LO busy counter.
//   Ports:
//     clk, reset            : clock, synchronous active-high reset
//     d_valid               : D holds a real instruction
//     d_rs, d_rt            : source registers
//     d_tuse_rs, d_tuse_rt  : cycles until operand needed, all-ones = unused
//     d_wr_en, d_wr_dst     : GRF write intent and destination
//     d_tnew                : cycles after entering E until the result exists
//     d_md_start, d_md_div  : starts a mult/div; div selects the long latency
//     d_hilo_use            : instruction touches HI/LO
//     stall                 : freeze PC and F/D, bubble into E
//     fwd_rs, fwd_rt        : 0 = GRF, k = forward from stage k
//     md_busy               : HI/LO unit computing
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int  NREG     = 32,
  parameter int  STAGES   = 3,
  parameter int  TW       = 3,
  parameter int  MULT_LAT = 5,
  parameter int  DIV_LAT  = 10,
  localparam int REG_W    = $clog2(NREG),
  localparam int FW       = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [TW-1:0]    d_tuse_rs,
  input  logic [TW-1:0]    d_tuse_rt,
  input  logic             d_wr_en,
  input  logic [REG_W-1:0] d_wr_dst,
  input  logic [TW-1:0]    d_tnew,
  input  logic             d_md_start,
  input  logic             d_md_div,
  input  logic             d_hilo_use,
  output logic             stall,
  output logic [FW-1:0]    fwd_rs,
  output logic [FW-1:0]    fwd_rt,
  output logic             md_busy
);

  localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW     = $clog2(MD_MAX + 1);

  hz_entry_t       ent_q [STAGES];
  hz_entry_t       ent_d [STAGES];
  hz_entry_t       ent_new;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  logic            issue;
  logic            stall_hl;
  logic [1:0]      op_stall;
  logic [FW-1:0]   op_fwd  [2];
  logic [REG_W-1:0] op_src [2];
  logic [TW-1:0]   op_tuse [2];

  assign op_src[0]  = d_rs;
  assign op_src[1]  = d_rt;
  assign op_tuse[0] = d_tuse_rs;
  assign op_tuse[1] = d_tuse_rt;

  // One matcher per source operand (0 = rs, 1 = rt).
  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    hazard_match #(
      .STAGES (STAGES),
      .REG_W  (REG_W),
      .TW     (TW),
      .FW     (FW)
    ) u_match (
      .valid_i (d_valid),
      .src_i   (op_src[gi]),
      .tuse_i  (op_tuse[gi]),
      .ent_i   (ent_q),
      .stall_o (op_stall[gi]),
      .fwd_o   (op_fwd[gi])
    );
  end

  assign fwd_rs   = op_fwd[0];
  assign fwd_rt   = op_fwd[1];
  assign md_busy  = (cnt_q != '0);
  assign stall_hl = d_valid && d_hilo_use && md_busy;
  assign stall    = d_valid && (op_stall[0] || op_stall[1] || stall_hl);
  assign issue    = d_valid && !stall;

  // A stalled D inserts a bubble (invalid entry) into E.
  always_comb begin
    ent_new = '0;
    if (issue && d_wr_en && (d_wr_dst != '0)) begin
      ent_new.valid = 1'b1;
      ent_new.dst   = ENT_REG_W'(d_wr_dst);
      ent_new.tnew  = ENT_TW'(d_tnew);
    end
  end

  // Older entries always age: nothing downstream of D ever stalls.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_ent
    if (gi == 0) begin : g_head
      assign ent_d[gi] = ent_new;
    end else begin : g_age
      assign ent_d[gi] = '{valid: ent_q[gi-1].valid,
                           dst:   ent_q[gi-1].dst,
                           tnew:  tnew_age(ent_q[gi-1].tnew)};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        ent_q[gi] <= '0;
      end else begin
        ent_q[gi] <= ent_d[gi];
      end
    end
  end

  // The counter loads when the starter leaves D, so it is already nonzero
  // while the starter sits in E and a following HI/LO user stalls at once.
  always_comb begin
    cnt_d = cnt_q;
    if (issue && d_md_start) begin
      cnt_d = d_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NREG     = 32;
  localparam int STAGES   = 3;
  localparam int TW       = 3;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int REG_W    = 5;
  localparam int FW       = 2;
  localparam int N        = 7;   // operand not read

  logic             clk = 1'b0;
  logic             reset;
  logic             d_valid;
  logic [REG_W-1:0] d_rs, d_rt, d_wr_dst;
  logic [TW-1:0]    d_tuse_rs, d_tuse_rt, d_tnew;
  logic             d_wr_en, d_md_start, d_md_div, d_hilo_use;
  logic             stall, md_busy;
  logic [FW-1:0]    fwd_rs, fwd_rt;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NREG     (NREG),
    .STAGES   (STAGES),
    .TW       (TW),
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_wr_en    (d_wr_en),
    .d_wr_dst   (d_wr_dst),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_hilo_use (d_hilo_use),
    .stall      (stall),
    .fwd_rs     (fwd_rs),
    .fwd_rt     (fwd_rt),
    .md_busy    (md_busy)
  );

  typedef struct {
    int st;
    int frs;
    int frt;
    int bz;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic check_val(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Drive one D-stage instruction for one cycle, queue the expected
  // outputs, then pop and compare them mid-cycle.
  task automatic step(input int rst, input int v,
                      input int rs, input int urs, input int rt, input int urt,
                      input int we, input int dst, input int tn,
                      input int ms, input int md, input int hl,
                      input int e_st, input int e_frs, input int e_frt, input int e_bz);
    exp_t e;
    reset      = rst[0];
    d_valid    = v[0];
    d_rs       = REG_W'(rs);
    d_tuse_rs  = TW'(urs);
    d_rt       = REG_W'(rt);
    d_tuse_rt  = TW'(urt);
    d_wr_en    = we[0];
    d_wr_dst   = REG_W'(dst);
    d_tnew     = TW'(tn);
    d_md_start = ms[0];
    d_md_div   = md[0];
    d_hilo_use = hl[0];
    exp_q.push_back('{e_st, e_frs, e_frt, e_bz});
    @(negedge clk);
    e = exp_q.pop_front();
    check_val($sformatf("c%0d.stall", cyc), int'(stall), e.st);
    check_val($sformatf("c%0d.fwd_rs", cyc), int'(fwd_rs), e.frs);
    check_val($sformatf("c%0d.fwd_rt", cyc), int'(fwd_rt), e.frt);
    check_val($sformatf("c%0d.md_busy", cyc), int'(md_busy), e.bz);
    $display("cyc %0d rst=%0d v=%0d rs=%0d rt=%0d -> stall=%0d fwd_rs=%0d fwd_rt=%0d md_busy=%0d",
             cyc, rst, v, rs, rt, stall, fwd_rs, fwd_rt, md_busy);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    reset = 1'b1; d_valid = 1'b0; d_rs = '0; d_rt = '0; d_tuse_rs = '1; d_tuse_rt = '1;
    d_wr_en = 1'b0; d_wr_dst = '0; d_tnew = '0; d_md_start = 1'b0; d_md_div = 1'b0;
    d_hilo_use = 1'b0;
    @(posedge clk);
    #1;

    // rst v  rs urs rt urt  we dst tn  ms md hl   st frs frt bz
    step(1, 0,  0, N,  0, N,  0, 0, 0,  0, 0, 0,   0, 0, 0, 0);
    step(0, 1,  8, 0,  0, N,  0, 0, 0,  0, 0, 0,   0, 0, 0, 0);
    // load r8, then addu r9,r8,r8
    step(0, 1, 29, 1,  0, N,  1, 8, int'(TNEW_LOAD), 0, 0, 0,   0, 0, 0, 0);
    step(0, 1,  8, 1,  8, 1,  1, 9, int'(TNEW_ALU),  0, 0, 0,   1, 0, 0, 0);
    step(0, 1,  8, 1,  8, 1,  1, 9, int'(TNEW_ALU),  0, 0, 0,   0, 0, 0, 0);
    step(0, 1,  8, 1,  9, 1,  0, 0, 0,  0, 0, 0,   0, 3, 0, 0);
    step(0, 1,  9, 0,  0, 0,  0, 0, 0,  0, 0, 0,   0, 2, 0, 0);
    // addu r8, then beq r8,r8
    step(0, 1,  9, 1,  0, N,  1, 8, 1,  0, 0, 0,   0, 3, 0, 0);
    step(0, 1,  8, 0,  8, 0,  0, 0, 0,  0, 0, 0,   1, 0, 0, 0);
    step(0, 1,  8, 0,  8, 0,  0, 0, 0,  0, 0, 0,   0, 2, 2, 0);
    // jal, then jr r31
    step(0, 1,  0, N,  0, N,  1, 31, int'(TNEW_PC8), 0, 0, 0,   0, 0, 0, 0);
    step(0, 1, 31, 0,  0, N,  0, 0, 0,  0, 0, 0,   0, 1, 0, 0);
    // load r5, addu r5, then readers of r5 (youngest writer decides)
    step(0, 1,  4, 1,  0, N,  1, 5, 2,  0, 0, 0,   0, 0, 0, 0);
    step(0, 1,  6, 1,  7, 1,  1, 5, 1,  0, 0, 0,   0, 0, 0, 0);
    step(0, 1,  5, 1,  0, N,  0, 0, 0,  0, 0, 0,   0, 0, 0, 0);
    step(0, 1,  5, 1,  0, N,  0, 0, 0,  0, 0, 0,   0, 2, 0, 0);
    // older ready write to r10 shadowed by a younger not-ready one
    step(0, 1,  0, N,  0, N,  1, 10, 0, 0, 0, 0,   0, 0, 0, 0);
    step(0, 1,  1, 1,  0, N,  1, 10, 1, 0, 0, 0,   0, 0, 0, 0);
    step(0, 1, 10, 0, 10, 1,  0, 0, 0,  0, 0, 0,   1, 0, 0, 0);
    step(0, 1, 10, 0, 10, 1,  0, 0, 0,  0, 0, 0,   0, 2, 2, 0);
    step(0, 1, 10, 0, 10, N,  0, 0, 0,  0, 0, 0,   0, 3, 0, 0);
    // invalid D gives no forward; writes to r0 are never tracked
    step(0, 1,  0, N,  0, N,  1, 12, 0, 0, 0, 0,   0, 0, 0, 0);
    step(0, 0, 12, 0, 12, 0,  0, 0, 0,  0, 0, 0,   0, 0, 0, 0);
    step(0, 1,  0, N,  0, N,  1, 0, 2,  0, 0, 0,   0, 0, 0, 0);
    step(0, 1,  0, 0,  0, 0,  0, 0, 0,  0, 0, 0,   0, 0, 0, 0);
    // div then mflo: exactly DIV_LAT stall cycles
    step(0, 1,  2, 1,  3, 1,  0, 0, 0,  1, 1, 1,   0, 0, 0, 0);
    for (int i = 0; i < DIV_LAT; i++)
      step(0, 1, 0, N, 0, N,  1, 4, 1,  0, 0, 1,   1, 0, 0, 1);
    step(0, 1,  0, N,  0, N,  1, 4, 1,  0, 0, 1,   0, 0, 0, 0);
    // mult, unrelated instruction, then mfhi
    step(0, 1,  2, 1,  3, 1,  0, 0, 0,  1, 0, 1,   0, 0, 0, 0);
    step(0, 1,  0, N,  0, N,  0, 0, 0,  0, 0, 0,   0, 0, 0, 1);
    for (int i = 0; i < MULT_LAT - 1; i++)
      step(0, 1, 0, N, 0, N,  0, 0, 0,  0, 0, 1,   1, 0, 0, 1);
    step(0, 1,  0, N,  0, N,  0, 0, 0,  0, 0, 1,   0, 0, 0, 0);
    // reset in the middle of a div with mfhi waiting in D
    step(0, 1,  2, 1,  3, 1,  0, 0, 0,  1, 1, 1,   0, 0, 0, 0);
    step(0, 1,  0, N,  0, N,  0, 0, 0,  0, 0, 1,   1, 0, 0, 1);
    step(1, 1,  0, N,  0, N,  0, 0, 0,  0, 0, 1,   1, 0, 0, 1);
    step(1, 1,  0, N,  0, N,  1, 7, 2,  1, 1, 1,   0, 0, 0, 0);
    step(0, 1,  7, 0,  0, 0,  0, 0, 0,  0, 0, 1,   0, 0, 0, 0);

    check_val("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
